// File: rtl/alu_rr_arbiter.sv
// -----------------------------------------------------------------------------
// alu_rr_arbiter
//
// Shares one external 4-bit ALU between two requesters with a round-robin
// policy. Only one operation is in flight at a time:
//   IDLE : arbitrate between the requesters and accept one request
//   WAIT : drive the held operands to the ALU and wait ALU_LATENCY edges
//   RESP : present the captured result, tagged with the requester ID, until
//          the consumer takes it
// The ALU's result and carry are captured. The zero and sign flags are
// derived locally from the captured result.
//
// Parameters:
//   ALU_LATENCY  clock edges from ALU inputs presented to alu_out_i/alu_carry_i
//                valid (0..7; 0 = combinational ALU, 1 = registered ALU)
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   reqN_valid_i / reqN_ready_o  request handshake for requester N (0/1)
//   reqN_a_i, reqN_b_i           4-bit operands from requester N
//   reqN_op_i                    ALU select (00 add, 01 sub, 10 AND, 11 OR)
//   rsp_valid_o / rsp_ready_i    shared response handshake
//   rsp_id_o                     requester ID the response belongs to
//   rsp_out_o, rsp_carry_o       captured result and carry/borrow
//                                (carry is 0 for AND/OR)
//   rsp_zero_o, rsp_sign_o       result == 0, result[3]
//   alu_a_o, alu_b_o, alu_sel_o  operands and select driven to the ALU
//   alu_out_i, alu_carry_i       result and carry returned by the ALU
//   busy_o                       high while an operation is in flight
// -----------------------------------------------------------------------------
module alu_rr_arbiter #(
  parameter int unsigned ALU_LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst_n,

  input  logic       req0_valid_i,
  output logic       req0_ready_o,
  input  logic [3:0] req0_a_i,
  input  logic [3:0] req0_b_i,
  input  logic [1:0] req0_op_i,

  input  logic       req1_valid_i,
  output logic       req1_ready_o,
  input  logic [3:0] req1_a_i,
  input  logic [3:0] req1_b_i,
  input  logic [1:0] req1_op_i,

  output logic       rsp_valid_o,
  input  logic       rsp_ready_i,
  output logic       rsp_id_o,
  output logic [3:0] rsp_out_o,
  output logic       rsp_carry_o,
  output logic       rsp_zero_o,
  output logic       rsp_sign_o,

  output logic [3:0] alu_a_o,
  output logic [3:0] alu_b_o,
  output logic [1:0] alu_sel_o,
  input  logic [3:0] alu_out_i,
  input  logic       alu_carry_i,

  output logic       busy_o
);

  localparam logic [2:0] LatencyLoad = 3'(ALU_LATENCY);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] waitCnt_q, waitCnt_d;
  logic       lastGrant_q;

  logic [3:0] opA_q;
  logic [3:0] opB_q;
  logic [1:0] opSel_q;
  logic       opId_q;

  logic       rspId_q;
  logic [3:0] rspOut_q;
  logic       rspCarry_q;
  logic       rspZero_q;
  logic       rspSign_q;

  logic       anyValid;
  logic       grantId;
  logic       reqHandshake;
  logic       rspHandshake;
  logic       captureNow;
  logic [3:0] selA;
  logic [3:0] selB;
  logic [1:0] selOp;

  // Round-robin choice: a lone requester always wins; under contention the
  // requester that was not granted last time wins.
  always_comb begin
    anyValid = req0_valid_i | req1_valid_i;
    grantId  = 1'b0;
    if (req0_valid_i && req1_valid_i) begin
      grantId = ~lastGrant_q;
    end else if (req1_valid_i) begin
      grantId = 1'b1;
    end
  end

  always_comb begin
    selA  = req0_a_i;
    selB  = req0_b_i;
    selOp = req0_op_i;
    if (grantId) begin
      selA  = req1_a_i;
      selB  = req1_b_i;
      selOp = req1_op_i;
    end
  end

  // Any valid requester in IDLE is granted, so ready implies a handshake.
  // Holding in reset keeps both ready outputs low while the state reads IDLE.
  assign reqHandshake = rst_n && (state_q == IDLE) && anyValid;
  assign rspHandshake = (state_q == RESP) && rsp_ready_i;
  assign captureNow   = (state_q == WAIT) && (waitCnt_q == 3'd0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (reqHandshake) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (captureNow) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (rspHandshake) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    req0_ready_o = reqHandshake && !grantId;
    req1_ready_o = reqHandshake && grantId;
    rsp_valid_o  = (state_q == RESP);
    busy_o       = (state_q != IDLE);
  end

  // Latency counter: loaded on acceptance, counts down to zero in WAIT.
  // The capture happens in the cycle that sees zero.
  always_comb begin
    waitCnt_d = waitCnt_q;
    if (reqHandshake) begin
      waitCnt_d = LatencyLoad;
    end else if ((state_q == WAIT) && (waitCnt_q != 3'd0)) begin
      waitCnt_d = waitCnt_q - 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waitCnt_q <= 3'd0;
    end else begin
      waitCnt_q <= waitCnt_d;
    end
  end

  // Holding registers feed the ALU directly. They are only reloaded on the
  // next acceptance, so the ALU inputs keep their last value once the
  // operation has completed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opA_q       <= 4'd0;
      opB_q       <= 4'd0;
      opSel_q     <= 2'd0;
      opId_q      <= 1'b0;
      lastGrant_q <= 1'b1;
    end else if (reqHandshake) begin
      opA_q       <= selA;
      opB_q       <= selB;
      opSel_q     <= selOp;
      opId_q      <= grantId;
      lastGrant_q <= grantId;
    end
  end

  // Result capture. Logic ops (sel[1] set) never report a carry, whatever the
  // ALU drives on its carry pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rspId_q    <= 1'b0;
      rspOut_q   <= 4'd0;
      rspCarry_q <= 1'b0;
      rspZero_q  <= 1'b0;
      rspSign_q  <= 1'b0;
    end else if (captureNow) begin
      rspId_q    <= opId_q;
      rspOut_q   <= alu_out_i;
      rspCarry_q <= alu_carry_i && !opSel_q[1];
      rspZero_q  <= (alu_out_i == 4'd0);
      rspSign_q  <= alu_out_i[3];
    end
  end

  assign rsp_id_o    = rspId_q;
  assign rsp_out_o   = rspOut_q;
  assign rsp_carry_o = rspCarry_q;
  assign rsp_zero_o  = rspZero_q;
  assign rsp_sign_o  = rspSign_q;

  assign alu_a_o     = opA_q;
  assign alu_b_o     = opB_q;
  assign alu_sel_o   = opSel_q;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_rr_arbiter
//
// Bench for alu_rr_arbiter with a registered (latency 1) ALU model.
// Requests are queued per requester and presented by a driver process. A
// monitor pushes the reference response for every accepted request into a
// scoreboard queue and compares it when the response handshake happens.
// -----------------------------------------------------------------------------
module tb_alu_rr_arbiter;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
  } req_t;

  typedef struct packed {
    logic       id;
    logic [3:0] out;
    logic       carry;
    logic       zero;
    logic       sign;
  } rsp_t;

  logic       clk;
  logic       rst_n;
  logic       req0_valid, req0_ready;
  logic [3:0] req0_a, req0_b;
  logic [1:0] req0_op;
  logic       req1_valid, req1_ready;
  logic [3:0] req1_a, req1_b;
  logic [1:0] req1_op;
  logic       rsp_valid, rsp_ready;
  logic       rsp_id;
  logic [3:0] rsp_out;
  logic       rsp_carry, rsp_zero, rsp_sign;
  logic [3:0] alu_a, alu_b;
  logic [1:0] alu_sel;
  logic [3:0] alu_out;
  logic       alu_carry;
  logic       busy;

  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;

  logic logicCarry = 1'b0;

  req_t reqQ0[$];
  req_t reqQ1[$];
  rsp_t expQ[$];
  int   grantLog[$];
  int   acceptLog[$];
  int   rspHsLog[$];
  req_t curReq;
  logic hsFlag0 = 1'b0;
  logic hsFlag1 = 1'b0;
  logic prevRspValid = 1'b0;

  alu_rr_arbiter #(.ALU_LATENCY(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0_valid_i (req0_valid),
    .req0_ready_o (req0_ready),
    .req0_a_i     (req0_a),
    .req0_b_i     (req0_b),
    .req0_op_i    (req0_op),
    .req1_valid_i (req1_valid),
    .req1_ready_o (req1_ready),
    .req1_a_i     (req1_a),
    .req1_b_i     (req1_b),
    .req1_op_i    (req1_op),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_id_o     (rsp_id),
    .rsp_out_o    (rsp_out),
    .rsp_carry_o  (rsp_carry),
    .rsp_zero_o   (rsp_zero),
    .rsp_sign_o   (rsp_sign),
    .alu_a_o      (alu_a),
    .alu_b_o      (alu_b),
    .alu_sel_o    (alu_sel),
    .alu_out_i    (alu_out),
    .alu_carry_i  (alu_carry),
    .busy_o       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Registered ALU. For logic ops the carry pin follows logicCarry so the
  // bench can show that the arbiter masks it.
  always @(posedge clk) begin
    logic [4:0] r;
    case (alu_sel)
      2'b00:   r = {1'b0, alu_a} + {1'b0, alu_b};
      2'b01:   r = {1'b0, alu_a} - {1'b0, alu_b};
      2'b10:   r = {logicCarry, alu_a & alu_b};
      default: r = {logicCarry, alu_a | alu_b};
    endcase
    alu_out   <= r[3:0];
    alu_carry <= r[4];
  end

  function automatic rsp_t refRsp(input logic id, input req_t r);
    rsp_t e;
    e.id = id;
    case (r.op)
      2'b00: begin
        e.out   = r.a + r.b;
        e.carry = (int'(r.a) + int'(r.b)) > 15;
      end
      2'b01: begin
        e.out   = r.a - r.b;
        e.carry = (r.a < r.b);
      end
      2'b10: begin
        e.out   = r.a & r.b;
        e.carry = 1'b0;
      end
      default: begin
        e.out   = r.a | r.b;
        e.carry = 1'b0;
      end
    endcase
    e.zero = (e.out == 4'd0);
    e.sign = e.out[3];
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)",
               tag, actual, expected, cycle);
    end
  endtask

  // Driver: presents the head of each request queue, holding it stable until
  // the monitor has seen it accepted.
  initial begin
    req0_valid = 1'b0; req0_a = 4'd0; req0_b = 4'd0; req0_op = 2'd0;
    req1_valid = 1'b0; req1_a = 4'd0; req1_b = 4'd0; req1_op = 2'd0;
    forever begin
      @(posedge clk);
      #1;
      if (hsFlag0) begin
        hsFlag0 = 1'b0;
        if (reqQ0.size() > 0) reqQ0.delete(0);
      end
      if (hsFlag1) begin
        hsFlag1 = 1'b0;
        if (reqQ1.size() > 0) reqQ1.delete(0);
      end
      if (reqQ0.size() > 0) begin
        req0_valid = 1'b1;
        {req0_a, req0_b, req0_op} = reqQ0[0];
      end else begin
        req0_valid = 1'b0;
      end
      if (reqQ1.size() > 0) begin
        req1_valid = 1'b1;
        {req1_a, req1_b, req1_op} = reqQ1[0];
      end else begin
        req1_valid = 1'b0;
      end
    end
  end

  // Monitor and scoreboard, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        expQ.delete();
        prevRspValid = 1'b0;
      end else begin
        if (req0_valid && req0_ready) begin
          curReq = {req0_a, req0_b, req0_op};
          expQ.push_back(refRsp(1'b0, curReq));
          grantLog.push_back(0);
          acceptLog.push_back(cycle);
          hsFlag0 = 1'b1;
        end
        if (req1_valid && req1_ready) begin
          curReq = {req1_a, req1_b, req1_op};
          expQ.push_back(refRsp(1'b1, curReq));
          grantLog.push_back(1);
          acceptLog.push_back(cycle);
          hsFlag1 = 1'b1;
        end
        if (busy && !rsp_valid) begin
          checkOutput("aluA", alu_a, curReq.a);
          checkOutput("aluB", alu_b, curReq.b);
          checkOutput("aluSel", alu_sel, curReq.op);
        end
        if (rsp_valid && !prevRspValid) begin
          checkOutput("rspLatency", cycle - acceptLog[acceptLog.size()-1], 3);
        end
        if (rsp_valid && rsp_ready) begin
          rspHsLog.push_back(cycle);
          if (expQ.size() == 0) begin
            checkOutput("unexpectedRsp", 1, 0);
          end else begin
            rsp_t e;
            e = expQ.pop_front();
            checkOutput("rspId", rsp_id, e.id);
            checkOutput("rspOut", rsp_out, e.out);
            checkOutput("rspCarry", rsp_carry, e.carry);
            checkOutput("rspZero", rsp_zero, e.zero);
            checkOutput("rspSign", rsp_sign, e.sign);
          end
        end
        prevRspValid = rsp_valid;
      end
    end
  end

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "Rdy0"}, req0_ready, 0);
    checkOutput({tag, "Rdy1"}, req1_ready, 0);
    checkOutput({tag, "RspValid"}, rsp_valid, 0);
    checkOutput({tag, "RspId"}, rsp_id, 0);
    checkOutput({tag, "RspOut"}, rsp_out, 0);
    checkOutput({tag, "RspCarry"}, rsp_carry, 0);
    checkOutput({tag, "RspZero"}, rsp_zero, 0);
    checkOutput({tag, "RspSign"}, rsp_sign, 0);
    checkOutput({tag, "AluA"}, alu_a, 0);
    checkOutput({tag, "AluB"}, alu_b, 0);
    checkOutput({tag, "AluSel"}, alu_sel, 0);
    checkOutput({tag, "Busy"}, busy, 0);
  endtask

  task automatic applyReset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic waitIdle(input string tag, input int maxCycles);
    int n = 0;
    while ((reqQ0.size() != 0 || reqQ1.size() != 0 || expQ.size() != 0 || busy)
           && n < maxCycles) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput({tag, "Drained"}, (n < maxCycles), 1);
  endtask

  task automatic applyStimulus();
    int s;
    int n;

    // Reset values
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Single add from requester 0: 9 + 8
    s = grantLog.size();
    reqQ0.push_back('{a: 4'h9, b: 4'h8, op: 2'b00});
    waitIdle("t1", 30);
    checkOutput("t1Grant", grantLog[s], 0);

    // Contention right after reset: requester 0 wins first
    applyReset();
    s = grantLog.size();
    reqQ0.push_back('{a: 4'h3, b: 4'h3, op: 2'b01});
    reqQ1.push_back('{a: 4'hC, b: 4'hA, op: 2'b10});
    waitIdle("t2", 40);
    checkOutput("t2Grant0", grantLog[s], 0);
    checkOutput("t2Grant1", grantLog[s+1], 1);

    // Continuous contention, four ops back to back
    s = grantLog.size();
    reqQ0.push_back('{a: 4'h1, b: 4'h2, op: 2'b00});
    reqQ0.push_back('{a: 4'hF, b: 4'h1, op: 2'b00});
    reqQ1.push_back('{a: 4'h6, b: 4'h3, op: 2'b11});
    reqQ1.push_back('{a: 4'hA, b: 4'h5, op: 2'b01});
    waitIdle("t3", 60);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("t3Grant%0d", i), grantLog[s+i], i % 2);
    end
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("t3Spacing%0d", i),
                  acceptLog[s+i+1] - acceptLog[s+i], 4);
    end

    // Response back-pressure with requester 1 waiting
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    s = grantLog.size();
    reqQ0.push_back('{a: 4'h7, b: 4'h1, op: 2'b00});
    reqQ1.push_back('{a: 4'h4, b: 4'h4, op: 2'b10});
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!rsp_valid && n < 20);
    checkOutput("t4RspSeen", rsp_valid, 1);
    for (int i = 0; i < 5; i++) begin
      checkOutput("t4Valid", rsp_valid, 1);
      checkOutput("t4HoldOut", rsp_out, expQ[0].out);
      checkOutput("t4HoldId", rsp_id, expQ[0].id);
      checkOutput("t4HoldSign", rsp_sign, expQ[0].sign);
      checkOutput("t4Rdy0", req0_ready, 0);
      checkOutput("t4Rdy1", req1_ready, 0);
      checkOutput("t4Busy", busy, 1);
      @(negedge clk);
      #1;
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    waitIdle("t4", 30);
    checkOutput("t4Grant0", grantLog[s], 0);
    checkOutput("t4Grant1", grantLog[s+1], 1);
    checkOutput("t4NoBypass", acceptLog[s+1] - rspHsLog[rspHsLog.size()-2], 1);

    // Borrow on sub, then carry masked on OR
    logicCarry = 1'b1;
    reqQ1.push_back('{a: 4'h2, b: 4'h5, op: 2'b01});
    reqQ1.push_back('{a: 4'h1, b: 4'h2, op: 2'b11});
    waitIdle("t5", 30);
    logicCarry = 1'b0;

    // Reset in the middle of an operation
    s = grantLog.size();
    reqQ0.push_back('{a: 4'h5, b: 4'h5, op: 2'b00});
    n = 0;
    while (grantLog.size() == s && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput("t6Accepted", grantLog.size(), s + 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 checkAllZero("t6Async");
    repeat (2) @(posedge clk);
    reqQ1.push_back('{a: 4'h6, b: 4'h3, op: 2'b01});
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    checkOutput("t6Rdy1", req1_ready, 1);
    checkOutput("t6Rdy0", req0_ready, 0);
    checkOutput("t6Busy", busy, 0);
    waitIdle("t6", 30);
    checkOutput("t6LastGrant", grantLog[grantLog.size()-1], 1);
  endtask

  initial begin
    applyStimulus();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cycle);
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
Shares one 4-bit ALU (ops: 00 add, 01 sub, 10 AND, 11 OR) between two requesters using a round-robin policy. Each requester gets a valid/ready request channel. Results return on one shared valid/ready response channel tagged with the requester ID. The block drives the ALU operand/select inputs, waits a fixed latency, captures result and carry, and computes zero/sign flags itself; one operation is in flight at a time.

Parameters:
ALU_LATENCY, 1, clock edges from ALU inputs first presented to alu_out/alu_carry valid; legal range 0..7 (0 = combinational ALU, 1 = registered ALU)

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
req0_valid  input  1  requester 0 request valid
req0_ready  output  1  requester 0 accepted (handshake when valid&ready)
req0_a  input  4  requester 0 operand A
req0_b  input  4  requester 0 operand B
req0_op  input  2  requester 0 ALU select
req1_valid, req1_ready, req1_a, req1_b, req1_op  same as requester 0, for requester 1
rsp_valid  output  1  response valid
rsp_ready  input  1  response consumer ready
rsp_id  output  1  requester ID of response
rsp_out  output  4  ALU result
rsp_carry  output  1  carry/borrow (0 for AND/OR)
rsp_zero  output  1  rsp_out == 0
rsp_sign  output  1  rsp_out[3]
alu_a  output  4  operand A to ALU
alu_b  output  4  operand B to ALU
alu_sel  output  2  select to ALU
alu_out  input  4  ALU result
alu_carry  input  1  ALU carry
busy  output  1  state != IDLE

Behaviour:
- Reset (async, rst_n low): state IDLE; all outputs 0 (reqN_ready, rsp_*, alu_*, busy); wait counter 0; last_grant = 1 so requester 0 wins the first contention. Any in-flight op is discarded; no response is produced for it.
- States: IDLE -> WAIT -> RESP -> IDLE.
- IDLE, arbitration:
  - Grant = the only valid requester; if both are valid, grant the one != last_grant.
  - reqN_ready = (state==IDLE) && grant==N, combinational from valid and last_grant; never asserted outside IDLE.
  - On handshake (cycle 0): latch a, b, op, id into holding regs; load counter = ALU_LATENCY; last_grant <= id; go WAIT.
- WAIT:
  - alu_a/alu_b/alu_sel driven from holding regs, stable from cycle 1 to the end of the op. They hold their last value after the op completes and are not cleared.
  - Counter decrements once per cycle while nonzero.
  - In the cycle where the counter is 0, at the clock edge: capture rsp_out=alu_out; rsp_carry = alu_carry if op[1]==0, else 0; rsp_zero = (alu_out==0); rsp_sign = alu_out[3]; rsp_id = id; go RESP.
  - WAIT spans cycles 1..ALU_LATENCY+1.
- RESP:
  - rsp_valid=1 from cycle ALU_LATENCY+2; all rsp_* held stable until rsp_valid&rsp_ready.
  - On that handshake: rsp_valid<=0, go IDLE.
  - No bypass: a request pending during the RESP-handshake cycle is accepted in the following IDLE cycle at the earliest.
  - rsp_* fields retain their values after rsp_valid drops.
- Throughput: with rsp_ready held high, 1 op per ALU_LATENCY+3 cycles.
- Requester rule: valid is held with a stable payload until accepted. The arbiter re-evaluates every IDLE cycle; dropping valid before acceptance is tolerated, and that requester simply does not win.
- Arithmetic: the block performs no arithmetic on operands; widths pass through. Flags derive only from the captured 4-bit result.
- busy = 1 in WAIT and RESP.

Test Plan:
- Bench uses ALU model with ALU_LATENCY=1. Only req0 valid, a=9 b=8 op=00; handshake cycle 0 -> rsp_valid rises at cycle 3, rsp_id=0, out=0x1, carry=1, zero=0, sign=0.
- Both valid right after reset: req0 a=3 b=3 op=01; req1 a=0xC b=0xA op=10 -> req0 served first (out=0, carry=0, zero=1), then req1 (out=0x8, carry=0, sign=1, zero=0).
- Both valid continuously with rsp_ready=1 for 4 ops -> grant sequence 0,1,0,1; req_ready pulses spaced 4 cycles apart; alu_* stable through each WAIT.
- rsp_ready held low 5 cycles in RESP -> rsp_* constant; no reqN_ready; busy=1. Raise rsp_ready -> next request accepted on the cycle after the handshake.
- Sub 2-5 via req1 (op=01, ALU carry=1) -> out=0xD, carry=1, sign=1. Then OR 0x1|0x2 while the ALU model holds carry=1 -> out=0x3, carry forced 0.
- Assert rst_n low during WAIT -> all outputs 0 immediately (asynchronously); no response after release. Then req1 alone valid -> req1_ready asserted in the first cycle after reset release.
